rv_decode_exec: RTL and testbench
=================================

Name: rv_decode_exec

Overview:
- Registered decode/execute slice of the single-cycle RV32I datapath: control decode (controlUnit), immediate generation (immGen) and ALU, with the ALU operand-B mux.
- Takes the fetched instruction plus register-file read data (rs1/rs2 values).
- Produces the control word, immediate, ALU result and branch-taken flag, registered with 1-cycle latency.
- Feeds register-file writeback, data-memory address/enables and the PC-next mux.

Parameters:
- XLEN, 32, datapath width. Only 32 is required.

Ports:
- clock  in  1  rising-edge clock
- clear  in  1  asynchronous reset, active-high
- in_valid  in  1  instruction/operands valid this cycle
- instr  in  32  instruction word
- data_a  in  32  rs1 value
- data_b  in  32  rs2 value
- out_valid  out  1  registered in_valid
- signals  out  11  control word: [1:0] immSel, [2] AluSrc, [3] MemToReg, [4] RegWrite, [5] MemRead, [6] MemWrite, [7] Branch, [10:8] AluOp
- imm  out  32  sign-extended immediate
- alu_result  out  32  ALU result
- branch_taken  out  1  Branch & compare-true
- illegal  out  1  opcode not supported

Behaviour:
- Reset: while clear is high, all outputs are 0, asynchronously. Outputs first update on the first rising clock edge after clear falls.
- Latency: every rising edge captures the combinational decode/execute of the current inputs. Outputs are valid one cycle after the inputs, pipelined, with a new result every cycle.
- out_valid <= in_valid. When in_valid is 0, outputs still update, but signals and branch_taken are forced to 0.
- Decode by opcode instr[6:0]:
  - 0110011 R-type: RegWrite=1, AluOp=010, immSel=00, AluSrc=0.
  - 0010011 I-ALU: RegWrite=1, AluSrc=1, AluOp=011, immSel=00.
  - 0000011 load: MemRead=1, MemToReg=1, RegWrite=1, AluSrc=1, AluOp=000, immSel=00.
  - 0100011 store: MemWrite=1, AluSrc=1, AluOp=000, immSel=01.
  - 1100011 branch: Branch=1, AluOp=001, immSel=10, AluSrc=0.
  - Any other opcode: signals=0, illegal=1, alu_result=0, branch_taken=0.
- Immediate selection:
  - immSel 00 (I): sext(instr[31:20]).
  - immSel 01 (S): sext({instr[31:25],instr[11:7]}).
  - immSel 10 (B): sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - immSel 11: 0.
- ALU operand B = AluSrc ? imm : data_b. func = {instr[30], instr[14:12]}.
- AluOp 000: add.
- AluOp 010, by func:
  - 0000 add, 1000 sub, 0001 sll, 0010 slt, 0011 sltu.
  - 0100 xor, 0101 srl, 1101 sra, 0110 or, 0111 and.
  - Other func values: 0.
- AluOp 011: same table, except:
  - func[3] is ignored for every funct3 other than 101, so addi never subtracts.
  - funct3 101 selects srai when instr[30]=1, else srli.
- Shift rules: shift amount = B[4:0]. slt/sltu produce 32'h0/32'h1.
- AluOp 001 (branch):
  - alu_result = A - B (mod 2^32).
  - Compare by funct3: 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu. 010/011 never taken.
  - branch_taken = compare result.
- branch_taken is 0 for all non-branch ops.
- All arithmetic wraps modulo 2^32. No overflow or exception flags.

Decomposition:
- Package rv_pkg: opcode constants, signals bit-position constants, immSel codes, AluOp codes, ALU func codes.
- One sub-module, rv_alu: purely combinational. Takes A, B, func, AluOp; produces result and compare.
- Decode and immediate logic live in rv_decode_exec with a single output register stage.

Test Plan:
- Reset: assert clear mid-stream with in_valid=1 -> all outputs 0 immediately. After release, next edge gives correct outputs.
- addi 0x00a00093, data_a=0 -> signals=0x314, imm=10, alu_result=10. Also 0x01400113 -> alu_result=20.
- sw 0x00202223, data_a=0, data_b=20 -> signals=0x045, imm=4, alu_result=4.
- lw 0x00402203 -> signals=0x03C, imm=4, alu_result=4.
- Register ALU ops:
  - add 0x004182b3, A=1, B=2 -> signals=0x210, alu_result=3.
  - sub 0x40208033, A=5, B=7 -> 0xFFFFFFFE.
  - srai 0x4040D093, A=0x80000000 -> 0xF8000000.
- Branch and illegal:
  - beq 0x00208463, A=B=7 -> signals=0x182, imm=8, branch_taken=1.
  - Same with B=6 -> branch_taken=0.
  - opcode 0x7F -> illegal=1, signals=0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared encodings for the RV32I decode/execute slice: opcodes, control-word bit
// positions, immediate-select, ALU-op and ALU function codes.
package rv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam int SIG_W        = 11;
    localparam int SIG_IMMSEL   = 0;
    localparam int SIG_ALUSRC   = 2;
    localparam int SIG_MEMTOREG = 3;
    localparam int SIG_REGWRITE = 4;
    localparam int SIG_MEMREAD  = 5;
    localparam int SIG_MEMWRITE = 6;
    localparam int SIG_BRANCH   = 7;
    localparam int SIG_ALUOP    = 8;

    localparam logic [1:0] IMM_I    = 2'b00;
    localparam logic [1:0] IMM_S    = 2'b01;
    localparam logic [1:0] IMM_B    = 2'b10;
    localparam logic [1:0] IMM_NONE = 2'b11;

    localparam logic [2:0] ALUOP_ADD = 3'b000;
    localparam logic [2:0] ALUOP_BR  = 3'b001;
    localparam logic [2:0] ALUOP_R   = 3'b010;
    localparam logic [2:0] ALUOP_I   = 3'b011;

    localparam logic [3:0] FN_ADD  = 4'b0000;
    localparam logic [3:0] FN_SUB  = 4'b1000;
    localparam logic [3:0] FN_SLL  = 4'b0001;
    localparam logic [3:0] FN_SLT  = 4'b0010;
    localparam logic [3:0] FN_SLTU = 4'b0011;
    localparam logic [3:0] FN_XOR  = 4'b0100;
    localparam logic [3:0] FN_SRL  = 4'b0101;
    localparam logic [3:0] FN_SRA  = 4'b1101;
    localparam logic [3:0] FN_OR   = 4'b0110;
    localparam logic [3:0] FN_AND  = 4'b0111;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

endpackage

// File: rtl/rv_alu.sv
// Combinational RV32I ALU: arithmetic/logic/shift table plus branch compare.
// Zero latency, no flow control.
module rv_alu
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [3:0]      func_i,
    input  logic [2:0]      alu_op_i,
    output logic [XLEN-1:0] result_o,
    output logic            cmp_o
);

    logic [3:0]      fn;
    logic [4:0]      shamt;
    logic [XLEN-1:0] table_res;

    always_comb begin
        shamt = b_i[4:0];
        fn    = func_i;
        // I-type ops reuse bit 30 as immediate data, so it only selects srai vs srli
        if (alu_op_i == ALUOP_I && func_i[2:0] != 3'b101) begin
            fn = {1'b0, func_i[2:0]};
        end

        table_res = '0;
        case (fn)
            FN_ADD:  table_res = a_i + b_i;
            FN_SUB:  table_res = a_i - b_i;
            FN_SLL:  table_res = a_i << shamt;
            FN_SLT:  table_res = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            FN_SLTU: table_res = {{(XLEN-1){1'b0}}, a_i < b_i};
            FN_XOR:  table_res = a_i ^ b_i;
            FN_SRL:  table_res = a_i >> shamt;
            FN_SRA:  table_res = $signed(a_i) >>> shamt;
            FN_OR:   table_res = a_i | b_i;
            FN_AND:  table_res = a_i & b_i;
            default: table_res = '0;
        endcase

        cmp_o = 1'b0;
        if (alu_op_i == ALUOP_BR) begin
            case (func_i[2:0])
                BR_EQ:   cmp_o = (a_i == b_i);
                BR_NE:   cmp_o = (a_i != b_i);
                BR_LT:   cmp_o = ($signed(a_i) < $signed(b_i));
                BR_GE:   cmp_o = ($signed(a_i) >= $signed(b_i));
                BR_LTU:  cmp_o = (a_i < b_i);
                BR_GEU:  cmp_o = (a_i >= b_i);
                default: cmp_o = 1'b0;
            endcase
        end

        case (alu_op_i)
            ALUOP_ADD: result_o = a_i + b_i;
            ALUOP_BR:  result_o = a_i - b_i;
            ALUOP_R,
            ALUOP_I:   result_o = table_res;
            default:   result_o = '0;
        endcase
    end

endmodule

// File: rtl/rv_decode_exec.sv
// Registered RV32I decode/execute: control word, immediate, ALU result, branch flag.
// One-cycle latency, a new result every cycle, no backpressure.
module rv_decode_exec
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  data_a,
    input  logic [XLEN-1:0]  data_b,
    output logic             out_valid,
    output logic [SIG_W-1:0] signals,
    output logic [XLEN-1:0]  imm,
    output logic [XLEN-1:0]  alu_result,
    output logic             branch_taken,
    output logic             illegal
);

    logic [SIG_W-1:0] sig;
    logic [XLEN-1:0]  imm_val;
    logic [XLEN-1:0]  op_b;
    logic [XLEN-1:0]  alu_res;
    logic             alu_cmp;
    logic             illegal_d;
    logic             unused_rs1;

    logic             out_valid_d, out_valid_q;
    logic [SIG_W-1:0] signals_d, signals_q;
    logic [XLEN-1:0]  imm_d, imm_q;
    logic [XLEN-1:0]  alu_result_d, alu_result_q;
    logic             branch_taken_d, branch_taken_q;
    logic             illegal_q;

    // rs1 index is resolved by the register file upstream
    assign unused_rs1 = ^instr[19:15];

    always_comb begin
        sig       = '0;
        illegal_d = 1'b0;
        case (instr[6:0])
            OP_R: begin
                sig[SIG_REGWRITE]     = 1'b1;
                sig[SIG_ALUOP +: 3]   = ALUOP_R;
            end
            OP_I: begin
                sig[SIG_REGWRITE]     = 1'b1;
                sig[SIG_ALUSRC]       = 1'b1;
                sig[SIG_ALUOP +: 3]   = ALUOP_I;
            end
            OP_LOAD: begin
                sig[SIG_MEMREAD]      = 1'b1;
                sig[SIG_MEMTOREG]     = 1'b1;
                sig[SIG_REGWRITE]     = 1'b1;
                sig[SIG_ALUSRC]       = 1'b1;
                sig[SIG_ALUOP +: 3]   = ALUOP_ADD;
            end
            OP_STORE: begin
                sig[SIG_MEMWRITE]     = 1'b1;
                sig[SIG_ALUSRC]       = 1'b1;
                sig[SIG_ALUOP +: 3]   = ALUOP_ADD;
                sig[SIG_IMMSEL +: 2]  = IMM_S;
            end
            OP_BRANCH: begin
                sig[SIG_BRANCH]       = 1'b1;
                sig[SIG_ALUOP +: 3]   = ALUOP_BR;
                sig[SIG_IMMSEL +: 2]  = IMM_B;
            end
            default: illegal_d = 1'b1;
        endcase

        case (sig[SIG_IMMSEL +: 2])
            IMM_I:    imm_val = {{(XLEN-12){instr[31]}}, instr[31:20]};
            IMM_S:    imm_val = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:    imm_val = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                                 instr[30:25], instr[11:8], 1'b0};
            default:  imm_val = '0;
        endcase

        op_b = sig[SIG_ALUSRC] ? imm_val : data_b;
    end

    rv_alu #(.XLEN(XLEN)) u_alu (
        .a_i      (data_a),
        .b_i      (op_b),
        .func_i   ({instr[30], instr[14:12]}),
        .alu_op_i (sig[SIG_ALUOP +: 3]),
        .result_o (alu_res),
        .cmp_o    (alu_cmp)
    );

    // Datapath outputs keep flowing when idle; only control is squashed
    always_comb begin
        out_valid_d    = in_valid;
        signals_d      = in_valid ? sig : '0;
        imm_d          = imm_val;
        alu_result_d   = illegal_d ? '0 : alu_res;
        branch_taken_d = in_valid & sig[SIG_BRANCH] & alu_cmp;
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            out_valid_q    <= 1'b0;
            signals_q      <= '0;
            imm_q          <= '0;
            alu_result_q   <= '0;
            branch_taken_q <= 1'b0;
            illegal_q      <= 1'b0;
        end else begin
            out_valid_q    <= out_valid_d;
            signals_q      <= signals_d;
            imm_q          <= imm_d;
            alu_result_q   <= alu_result_d;
            branch_taken_q <= branch_taken_d;
            illegal_q      <= illegal_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign signals      = signals_q;
    assign imm          = imm_q;
    assign alu_result   = alu_result_q;
    assign branch_taken = branch_taken_q;
    assign illegal      = illegal_q;

endmodule

// File: tb/tb_rv_decode_exec.sv
// Directed bench for rv_decode_exec: expected results queued at drive time,
// popped and compared one cycle later.
module tb_rv_decode_exec;

    logic        clock = 1'b0;
    logic        clear;
    logic        in_valid;
    logic [31:0] instr;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        out_valid;
    logic [10:0] signals;
    logic [31:0] imm;
    logic [31:0] alu_result;
    logic        branch_taken;
    logic        illegal;

    always #5 clock = ~clock;

    rv_decode_exec #(.XLEN(32)) dut (
        .clock        (clock),
        .clear        (clear),
        .in_valid     (in_valid),
        .instr        (instr),
        .data_a       (data_a),
        .data_b       (data_b),
        .out_valid    (out_valid),
        .signals      (signals),
        .imm          (imm),
        .alu_result   (alu_result),
        .branch_taken (branch_taken),
        .illegal      (illegal)
    );

    typedef struct packed {
        logic        vld;
        logic [10:0] sig;
        logic [31:0] imm;
        logic [31:0] alu;
        logic        bt;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".out_valid"},    {31'b0, out_valid},    32'h0);
        check({tag, ".signals"},      {21'b0, signals},      32'h0);
        check({tag, ".imm"},          imm,                   32'h0);
        check({tag, ".alu_result"},   alu_result,            32'h0);
        check({tag, ".branch_taken"}, {31'b0, branch_taken}, 32'h0);
        check({tag, ".illegal"},      {31'b0, illegal},      32'h0);
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s.scoreboard: observed empty queue expected an entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, ".out_valid"},    {31'b0, out_valid},    {31'b0, e.vld});
            check({tag, ".signals"},      {21'b0, signals},      {21'b0, e.sig});
            check({tag, ".imm"},          imm,                   e.imm);
            check({tag, ".alu_result"},   alu_result,            e.alu);
            check({tag, ".branch_taken"}, {31'b0, branch_taken}, {31'b0, e.bt});
            check({tag, ".illegal"},      {31'b0, illegal},      {31'b0, e.ill});
        end
    endtask

    task automatic step_now(input string tag, input logic [31:0] ins, input logic [31:0] a,
                            input logic [31:0] b, input logic v, input logic [10:0] s,
                            input logic [31:0] im, input logic [31:0] al,
                            input logic bt, input logic il);
        exp_t e;
        instr    = ins;
        data_a   = a;
        data_b   = b;
        in_valid = v;
        e.vld = v; e.sig = s; e.imm = im; e.alu = al; e.bt = bt; e.ill = il;
        sb.push_back(e);
        @(posedge clock);
        #1;
        compare_out(tag);
    endtask

    task automatic step(input string tag, input logic [31:0] ins, input logic [31:0] a,
                        input logic [31:0] b, input logic v, input logic [10:0] s,
                        input logic [31:0] im, input logic [31:0] al,
                        input logic bt, input logic il);
        @(negedge clock);
        step_now(tag, ins, a, b, v, s, im, al, bt, il);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        clear    = 1'b1;
        in_valid = 1'b1;
        instr    = 32'h00a00093;
        data_a   = 32'h0;
        data_b   = 32'h0;
        #1;
        check_zero("reset_initial");
        @(posedge clock);
        #1;
        check_zero("reset_edge");
        @(negedge clock);
        clear = 1'b0;

        //         tag         instr         A             B            v  sig     imm           alu           bt il
        step("addi10",  32'h00a00093, 32'h0,        32'h0,        1, 11'h314, 32'd10,       32'd10,       0, 0);
        step("addi20",  32'h01400113, 32'h0,        32'h0,        1, 11'h314, 32'd20,       32'd20,       0, 0);
        step("sw",      32'h00202223, 32'h0,        32'd20,       1, 11'h045, 32'd4,        32'd4,        0, 0);
        step("lw",      32'h00402203, 32'h0,        32'h0,        1, 11'h03C, 32'd4,        32'd4,        0, 0);
        step("add",     32'h004182b3, 32'd1,        32'd2,        1, 11'h210, 32'd4,        32'd3,        0, 0);
        step("sub",     32'h40208033, 32'd5,        32'd7,        1, 11'h210, 32'h402,      32'hFFFFFFFE, 0, 0);
        step("srai",    32'h4040D093, 32'h80000000, 32'h0,        1, 11'h314, 32'h404,      32'hF8000000, 0, 0);
        step("beq_t",   32'h00208463, 32'd7,        32'd7,        1, 11'h182, 32'd8,        32'd0,        1, 0);
        step("beq_nt",  32'h00208463, 32'd7,        32'd6,        1, 11'h182, 32'd8,        32'd1,        0, 0);
        step("illegal", 32'h0000007F, 32'd3,        32'd4,        1, 11'h000, 32'd0,        32'd0,        0, 1);
        step("bne_t",   32'h00209463, 32'd7,        32'd6,        1, 11'h182, 32'd8,        32'd1,        1, 0);
        step("blt_t",   32'h0020C463, 32'hFFFFFFFF, 32'd1,        1, 11'h182, 32'd8,        32'hFFFFFFFE, 1, 0);
        step("bltu_nt", 32'h0020E463, 32'hFFFFFFFF, 32'd1,        1, 11'h182, 32'd8,        32'hFFFFFFFE, 0, 0);
        step("bgeu_t",  32'h0020F463, 32'hFFFFFFFF, 32'd1,        1, 11'h182, 32'd8,        32'hFFFFFFFE, 1, 0);
        step("br_f010", 32'h0020A463, 32'd3,        32'd3,        1, 11'h182, 32'd8,        32'd0,        0, 0);
        step("beq_idle",32'h00208463, 32'd7,        32'd7,        0, 11'h000, 32'd8,        32'd0,        0, 0);
        step("ill_idle",32'h0000007F, 32'd3,        32'd4,        0, 11'h000, 32'd0,        32'd0,        0, 1);
        step("sltu",    32'h0020B0B3, 32'd1,        32'hFFFFFFFF, 1, 11'h210, 32'd2,        32'd1,        0, 0);
        step("slt",     32'h0020A0B3, 32'd1,        32'hFFFFFFFF, 1, 11'h210, 32'd2,        32'd0,        0, 0);
        step("r_f1001", 32'h402090B3, 32'd3,        32'd1,        1, 11'h210, 32'h402,      32'd0,        0, 0);
        step("xor",     32'h0020C0B3, 32'h0000F0F0, 32'h0000FF00, 1, 11'h210, 32'd2,        32'h00000FF0, 0, 0);
        step("or",      32'h0020E0B3, 32'h0000F0F0, 32'h0000FF00, 1, 11'h210, 32'd2,        32'h0000FFF0, 0, 0);
        step("and",     32'h0020F0B3, 32'h0000F0F0, 32'h0000FF00, 1, 11'h210, 32'd2,        32'h0000F000, 0, 0);
        step("sra",     32'h4020D0B3, 32'h80000000, 32'h00000024, 1, 11'h210, 32'h402,      32'hF8000000, 0, 0);
        step("srl",     32'h0020D0B3, 32'h80000000, 32'h00000024, 1, 11'h210, 32'd2,        32'h08000000, 0, 0);
        step("addi_b30",32'h40008093, 32'd5,        32'h0,        1, 11'h314, 32'h400,      32'h405,      0, 0);
        step("slli_b30",32'h40209093, 32'd3,        32'h0,        1, 11'h314, 32'h402,      32'd12,       0, 0);
        step("srli",    32'h0040D093, 32'h80000000, 32'h0,        1, 11'h314, 32'd4,        32'h08000000, 0, 0);
        step("addi_m1", 32'hFFF08093, 32'd5,        32'h0,        1, 11'h314, 32'hFFFFFFFF, 32'd4,        0, 0);
        step("sw_neg",  32'hFE20AE23, 32'h100,      32'h55,       1, 11'h045, 32'hFFFFFFFC, 32'h000000FC, 0, 0);

        // Mid-stream asynchronous reset with a valid instruction on the inputs
        @(negedge clock);
        instr    = 32'h01400113;
        data_a   = 32'h0;
        data_b   = 32'h0;
        in_valid = 1'b1;
        #2;
        clear = 1'b1;
        #1;
        check_zero("reset_async");
        @(posedge clock);
        #1;
        check_zero("reset_hold");
        @(negedge clock);
        clear = 1'b0;
        step_now("post_reset", 32'h01400113, 32'h0, 32'h0, 1, 11'h314, 32'd20, 32'd20, 0, 0);
        step("post_beq", 32'h00208463, 32'd7, 32'd7, 1, 11'h182, 32'd8, 32'd0, 1, 0);

        check("scoreboard_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
